// File: rtl/lab7_fifo_queue.sv
`default_nettype none
// ============================================================================
//  Module      : lab7_fifo_queue
//  Description : Synchronous FIFO queue with occupancy flags and one-cycle
//                overflow/underflow pulses; registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module lab7_fifo_queue #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0]   c_DEPTH   = (PTR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] c_PTR_ONE = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   c_CNT_ONE = (PTR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  r_head;
    logic [PTR_WIDTH-1:0]  r_tail;
    logic [PTR_WIDTH:0]    r_count;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    // A pop on a full queue frees the slot the simultaneous push reuses.
    assign w_do_push = push & (~w_full | pop);
    assign w_do_pop  = pop & ~w_empty;

    // Storage is deliberately not reset; pointers define what is valid.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_tail] <= write_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_read_data <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= push & w_full & ~pop;
            r_underflow <= pop & w_empty;
            if (w_do_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_read_data <= r_mem[r_head];
                r_head      <= r_head + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign read_data = r_read_data;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_lab7_fifo_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab7_fifo_queue
//  Description : Directed self-checking bench for lab7_fifo_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lab7_fifo_queue;

    logic       clock;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_pass   = 0;

    lab7_fifo_queue #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then settle just after the edge.
    task automatic cyc(input logic p, input logic q, input logic [7:0] d);
        push       = p;
        pop        = q;
        write_data = d;
        @(posedge clock);
        #1;
        push       = 1'b0;
        pop        = 1'b0;
        write_data = 8'h00;
    endtask

    initial begin
        push       = 1'b0;
        pop        = 1'b0;
        write_data = 8'h00;
        reset      = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rdata", 32'(read_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);

        // Ordering
        cyc(1'b1, 1'b0, 8'hA1);
        check("ord_cnt1", 32'(count), 32'd1);
        check("ord_nempty", 32'(empty), 32'd0);
        cyc(1'b1, 1'b0, 8'hB2);
        cyc(1'b1, 1'b0, 8'hC3);
        check("ord_cnt3", 32'(count), 32'd3);
        cyc(1'b0, 1'b1, 8'h00);
        check("ord_pop1", 32'(read_data), 32'hA1);
        check("ord_cnt2", 32'(count), 32'd2);
        cyc(1'b0, 1'b1, 8'h00);
        check("ord_pop2", 32'(read_data), 32'hB2);
        cyc(1'b0, 1'b1, 8'h00);
        check("ord_pop3", 32'(read_data), 32'hC3);
        check("ord_cnt0", 32'(count), 32'd0);
        check("ord_empty", 32'(empty), 32'd1);

        // Full and overflow
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_cnt", 32'(count), 32'd4);
        cyc(1'b1, 1'b0, 8'h14);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_cnt", 32'(count), 32'd4);
        cyc(1'b0, 1'b0, 8'h00);
        check("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("full_drain", 32'(read_data), 32'h10 + 32'(i));
        end
        check("full_empty", 32'(empty), 32'd1);

        // Underflow, including push+pop on empty
        cyc(1'b0, 1'b1, 8'h00);
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_rdata", 32'(read_data), 32'h13);
        cyc(1'b1, 1'b1, 8'h5A);
        check("unf_pp_pulse", 32'(underflow), 32'd1);
        check("unf_pp_cnt", 32'(count), 32'd1);
        check("unf_pp_rdata", 32'(read_data), 32'h13);
        cyc(1'b0, 1'b1, 8'h00);
        check("unf_pop5a", 32'(read_data), 32'h5A);
        check("unf_clear", 32'(underflow), 32'd0);
        check("unf_cnt0", 32'(count), 32'd0);

        // Full plus simultaneous push/pop, wrap-around
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i));
        cyc(1'b1, 1'b1, 8'h24);
        check("wrap_rdata", 32'(read_data), 32'h20);
        check("wrap_cnt", 32'(count), 32'd4);
        check("wrap_novf", 32'(overflow), 32'd0);
        check("wrap_full", 32'(full), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("wrap_drain", 32'(read_data), 32'h20 + 32'(i));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-cycle
        cyc(1'b1, 1'b0, 8'h33);
        cyc(1'b1, 1'b0, 8'h44);
        check("mid_cnt2", 32'(count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_cnt", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_rdata", 32'(read_data), 32'h00);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_hold", 32'(count), 32'd0);
        cyc(1'b1, 1'b0, 8'h55);
        check("mid_cnt1", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        check("mid_pop55", 32'(read_data), 32'h55);
        check("mid_end", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
